// File: rtl/ram_responder.sv
// Single-port word RAM behind a busy/valid handshake. Each accepted request
// stalls the initiator for LATENCY wait cycles, then one DONE cycle follows.
module ram_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        Ren,
    input  logic        Wen,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [31:0]         data_out_q, data_out_d;

    logic [31:0]         mem [DEPTH];

    logic                req;
    logic [ADDR_W-1:0]   idx_in;
    logic                acc_en, acc_wr;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_wdat;

    // Byte-offset bits and bits above the array alias away.
    logic                unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign req    = Ren || Wen;
    assign idx_in = addr[ADDR_W+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        wdat_d   = wdat_q;
        acc_en   = 1'b0;
        acc_wr   = wr_q;
        acc_idx  = idx_q;
        acc_wdat = wdat_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d   = Wen;
                    idx_d  = idx_in;
                    wdat_d = data_in;
                    cnt_d  = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        // Zero-wait build: access straight from the live inputs.
                        acc_en   = 1'b1;
                        acc_wr   = Wen;
                        acc_idx  = idx_in;
                        acc_wdat = data_in;
                        state_d  = DONE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_en  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign data_out_d = (acc_en && !acc_wr) ? mem[acc_idx] : data_out_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdat_q     <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            wdat_q     <= wdat_d;
            data_out_q <= data_out_d;
        end
    end

    // Array is never reset; the nRST gate keeps a write from landing while held in reset.
    always_ff @(posedge clk) begin
        if (nRST && acc_en && acc_wr) mem[acc_idx] <= acc_wdat;
    end

    assign data_out = data_out_q;
    assign busy     = (state_q == IDLE && req) || (state_q == WAIT);

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three builds (LATENCY 2, 0, 3) driven by directed and
// random transactions, checked against a word-array model of the memory.
module tb_ram_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LATS [NDUT] = '{2, 0, 3};

    logic        clk = 1'b0;
    logic        nRST;
    logic        ren_s  [NDUT];
    logic        wen_s  [NDUT];
    logic [31:0] addr_s [NDUT];
    logic [31:0] din_s  [NDUT];
    logic [31:0] dout_s [NDUT];
    logic        busy_s [NDUT];

    logic [31:0] mmem  [NDUT][DEPTH];
    logic [31:0] mdout [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ram_responder #(.DEPTH(DEPTH), .LATENCY(LATS[g])) u_dut (
            .clk      (clk),
            .nRST     (nRST),
            .Ren      (ren_s[g]),
            .Wen      (wen_s[g]),
            .addr     (addr_s[g]),
            .data_in  (din_s[g]),
            .data_out (dout_s[g]),
            .busy     (busy_s[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request, optionally held across reps DONE cycles. Called just after a
    // negedge in an idle cycle; returns just after a negedge in an idle cycle.
    task automatic xact(input int d, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] dv, input int reps);
        int lat = LATS[d];
        logic [AW-1:0] idx = a[AW+1:2];
        ren_s[d] = r; wen_s[d] = w; addr_s[d] = a; din_s[d] = dv;
        for (int rep = 0; rep < reps; rep++) begin
            for (int c = 0; c <= lat; c++) begin
                if (c == 0 && rep == 0) #1;
                else @(negedge clk);
                chk($sformatf("busy_req d%0d c%0d", d, c), {31'b0, busy_s[d]}, 32'd1);
                if (c == 1 && reps == 1) begin
                    // Inputs during WAIT must be ignored.
                    addr_s[d] = $urandom; din_s[d] = $urandom;
                    ren_s[d] = 1'($urandom); wen_s[d] = 1'($urandom);
                end
            end
            @(negedge clk);
            if (w) mmem[d][idx] = dv;
            else   mdout[d] = mmem[d][idx];
            chk($sformatf("busy_done d%0d", d), {31'b0, busy_s[d]}, 32'd0);
            chk($sformatf("dout d%0d a%h", d, a), dout_s[d], mdout[d]);
        end
        ren_s[d] = 1'b0; wen_s[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("busy_idle d%0d", d), {31'b0, busy_s[d]}, 32'd0);
    endtask

    initial begin
        nRST = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            ren_s[d] = 1'b0; wen_s[d] = 1'b0; addr_s[d] = '0; din_s[d] = '0;
            mdout[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("reset busy", {31'b0, busy_s[d]}, 32'd0);
            chk("reset dout", dout_s[d], 32'd0);
        end
        nRST = 1'b1;
        @(negedge clk);

        // Preload every word so later reads are defined.
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < DEPTH; i++)
                xact(d, 1'b1, 1'b0, {$urandom_range(0, 255), 22'(i), 2'($urandom)}, $urandom, 1);

        // Directed cases on the LATENCY=2 build.
        xact(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1);
        xact(0, 1'b0, 1'b1, 32'h10, 32'h0, 1);
        chk("read 0x10", dout_s[0], 32'hDEADBEEF);
        xact(0, 1'b1, 1'b0, 32'h104, 32'h12345678, 1);
        xact(0, 1'b0, 1'b1, 32'h007, 32'h0, 1);
        chk("alias 0x007", dout_s[0], 32'h12345678);
        xact(0, 1'b1, 1'b0, 32'h40, 32'h11111111, 1);
        xact(0, 1'b0, 1'b1, 32'h40, 32'h0, 1);
        xact(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1);
        chk("ren+wen keeps dout", dout_s[0], 32'h11111111);
        xact(0, 1'b0, 1'b1, 32'h20, 32'h0, 1);
        chk("ren+wen wrote", dout_s[0], 32'hA5A5A5A5);
        xact(0, 1'b0, 1'b1, 32'h10, 32'h0, 3);
        chk("held read", dout_s[0], 32'hDEADBEEF);

        // Reset in the middle of a pending write.
        xact(0, 1'b1, 1'b0, 32'h30, 32'h0, 1);
        xact(0, 1'b0, 1'b1, 32'h10, 32'h0, 1);
        wen_s[0] = 1'b1; addr_s[0] = 32'h30; din_s[0] = 32'hCAFEF00D;
        @(negedge clk);
        nRST = 1'b0;
        #1;
        chk("rst busy held", {31'b0, busy_s[0]}, 32'd1);
        for (int d = 0; d < NDUT; d++) begin
            mdout[d] = '0;
            chk("rst dout", dout_s[d], 32'd0);
        end
        wen_s[0] = 1'b0;
        #1;
        chk("rst busy drop", {31'b0, busy_s[0]}, 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        xact(0, 1'b0, 1'b1, 32'h30, 32'h0, 1);
        chk("write discarded", dout_s[0], 32'h0);

        // Zero-latency build: busy only in the request cycle.
        xact(1, 1'b1, 1'b0, 32'h8, 32'h0BADCAFE, 1);
        xact(1, 1'b0, 1'b1, 32'h8, 32'h0, 2);
        chk("lat0 read", dout_s[1], 32'h0BADCAFE);

        // Random mix on all builds.
        for (int n = 0; n < 60; n++) begin
            int d  = $urandom_range(0, NDUT - 1);
            int op = $urandom_range(0, 3);
            xact(d, op >= 2, op != 2, $urandom, $urandom,
                 ($urandom_range(0, 4) == 0) ? 2 : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
